// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer and the universal shift register it drives:
// mode codes, FSM state encoding and the shift counter width.
package shift_sequencer_pkg;

  // Mode codes understood by the downstream universal shift register
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Sequencer FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_LOAD  = 2'b01;
  localparam logic [1:0] ST_SHIFT = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  localparam int COUNT_W = 4;

endpackage

// File: rtl/shift_sequencer_if.sv
// Command channel into the shift sequencer: valid/ready handshake, command fields and abort.
interface shift_sequencer_if #(
  parameter int WIDTH = 4
);
  import shift_sequencer_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [COUNT_W-1:0] cmd_count;
  logic [WIDTH-1:0]   cmd_data;
  logic               cmd_fill;
  logic               abort;

  modport master (
    output cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill, abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill, abort,
    output cmd_ready
  );

endinterface

// File: rtl/shift_cycle_counter.sv
// 4-bit loadable down-counter; flags the last shift cycle (count == 1) and never wraps below 0.
module shift_cycle_counter
  import shift_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_en,
  input  logic [COUNT_W-1:0] load_val,
  input  logic               dec_en,
  output logic               last
);

  logic [COUNT_W-1:0] count_r;

  // Load on command acceptance, otherwise count down while enabled, saturating at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {COUNT_W{1'b0}};
    end else if (load_en) begin
      count_r <= load_val;
    end else if (dec_en && (count_r != {COUNT_W{1'b0}})) begin
      count_r <= count_r - {{(COUNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign last = (count_r == {{(COUNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven sequencer for a universal shift register: turns load/shift commands into
// registered MODE/DATAIN streams with busy/done status and a synchronous abort.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  shift_sequencer_if.slave cmd,
  output logic [1:0]       MODE,
  output logic [WIDTH-1:0] DATAIN,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_r, state_nxt_s;
  logic [1:0]       mode_r, mode_nxt_s;
  logic [WIDTH-1:0] datain_r, datain_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;
  logic             accept_s;
  logic             cnt_last_s;

  assign cmd.cmd_ready = (state_r == ST_IDLE) && !cmd.abort;
  assign accept_s      = cmd.cmd_valid && cmd.cmd_ready;

  shift_cycle_counter u_counter (
    .clk      (clock),
    .rst_n    (reset),
    .load_en  (accept_s),
    .load_val (cmd.cmd_count),
    .dec_en   (state_r == ST_SHIFT),
    .last     (cnt_last_s)
  );

  // Next-state and next-output decode; outputs describe the state being entered
  always_comb begin
    state_nxt_s  = state_r;
    mode_nxt_s   = MODE_HOLD;
    datain_nxt_s = datain_r;
    busy_nxt_s   = 1'b0;
    done_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (cmd.cmd_op)
            MODE_LOAD: begin
              state_nxt_s  = ST_LOAD;
              mode_nxt_s   = MODE_LOAD;
              datain_nxt_s = cmd.cmd_data;
              busy_nxt_s   = 1'b1;
            end
            MODE_SHR, MODE_SHL: begin
              if (cmd.cmd_count != {COUNT_W{1'b0}}) begin
                state_nxt_s  = ST_SHIFT;
                mode_nxt_s   = cmd.cmd_op;
                datain_nxt_s = {WIDTH{cmd.cmd_fill}};
                busy_nxt_s   = 1'b1;
              end else begin
                state_nxt_s = ST_DONE;
                done_nxt_s  = 1'b1;
              end
            end
            default: begin
              state_nxt_s = ST_DONE;
              done_nxt_s  = 1'b1;
            end
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cmd.abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
          done_nxt_s  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cmd.abort) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_last_s) begin
          state_nxt_s = ST_DONE;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_SHIFT;
          mode_nxt_s  = mode_r;
          busy_nxt_s  = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and registered output update
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      mode_r   <= MODE_HOLD;
      datain_r <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      mode_r   <= mode_nxt_s;
      datain_r <= datain_nxt_s;
      busy_r   <= busy_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

  assign MODE   = mode_r;
  assign DATAIN = datain_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a small universal shift register model downstream.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  localparam int W = 4;

  logic         clock;
  logic         reset;
  logic [1:0]   mode;
  logic [W-1:0] datain;
  logic         busy;
  logic         done;
  logic [W-1:0] q;

  int vectors;
  int miscompares;

  shift_sequencer_if #(.WIDTH(W)) cmd_if ();

  shift_sequencer #(.WIDTH(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .cmd    (cmd_if),
    .MODE   (mode),
    .DATAIN (datain),
    .busy   (busy),
    .done   (done)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Downstream universal shift register: serial bits enter from DATAIN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= 4'b0000;
    end else begin
      case (mode)
        MODE_SHR:  q <= {datain[W-1], q[W-1:1]};
        MODE_SHL:  q <= {q[W-2:0], datain[0]};
        MODE_LOAD: q <= datain;
        default:   q <= q;
      endcase
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [1:0] m, input logic [3:0] d,
                      input logic b, input logic dn);
    chk({tag, ".MODE"},   {6'd0, mode}, {6'd0, m});
    chk({tag, ".DATAIN"}, {4'd0, datain}, {4'd0, d});
    chk({tag, ".busy"},   {7'd0, busy}, {7'd0, b});
    chk({tag, ".done"},   {7'd0, done}, {7'd0, dn});
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] cnt, input logic [3:0] dat,
                      input logic fill);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_count = cnt;
    cmd_if.cmd_data  = dat;
    cmd_if.cmd_fill  = fill;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_count = 4'd0;
    cmd_if.cmd_data  = 4'b0000;
    cmd_if.cmd_fill  = 1'b0;
    cmd_if.abort     = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    outs("reset", 2'b00, 4'b0000, 1'b0, 1'b0);
    tick();
    tick();

    // Load 1010, offered together with reset release
    reset = 1'b1;
    send(2'b11, 4'd0, 4'b1010, 1'b0);
    #1;
    chk("ready_after_reset", {7'd0, cmd_if.cmd_ready}, 8'd1);
    tick();
    outs("load_cyc", 2'b11, 4'b1010, 1'b1, 1'b0);
    chk("ready_busy", {7'd0, cmd_if.cmd_ready}, 8'd0);
    cmd_if.cmd_valid = 1'b0;
    tick();
    outs("load_done", 2'b00, 4'b1010, 1'b0, 1'b1);
    chk("load_q", {4'd0, q}, 8'h0a);
    tick();
    outs("load_idle", 2'b00, 4'b1010, 1'b0, 1'b0);

    // Shift right by 2 with fill 0
    send(2'b01, 4'd2, 4'b0000, 1'b0);
    tick();
    outs("shr_c1", 2'b01, 4'b0000, 1'b1, 1'b0);
    cmd_if.cmd_valid = 1'b0;
    tick();
    outs("shr_c2", 2'b01, 4'b0000, 1'b1, 1'b0);
    chk("shr_q_mid", {4'd0, q}, 8'h05);
    tick();
    outs("shr_done", 2'b00, 4'b0000, 1'b0, 1'b1);
    chk("shr_q", {4'd0, q}, 8'h02);
    tick();
    chk("shr_done_clr", {7'd0, done}, 8'd0);

    // Zero-count shift left goes straight to DONE
    send(2'b10, 4'd0, 4'b0000, 1'b1);
    tick();
    outs("zero_done", 2'b00, 4'b0000, 1'b0, 1'b1);
    cmd_if.cmd_valid = 1'b0;
    tick();
    outs("zero_idle", 2'b00, 4'b0000, 1'b0, 1'b0);
    chk("zero_q", {4'd0, q}, 8'h02);

    // Shift left 15 with fill 1, aborted in the 3rd SHIFT cycle
    send(2'b10, 4'd15, 4'b0000, 1'b1);
    tick();
    outs("abt_c1", 2'b10, 4'b1111, 1'b1, 1'b0);
    cmd_if.cmd_valid = 1'b0;
    tick();
    outs("abt_c2", 2'b10, 4'b1111, 1'b1, 1'b0);
    tick();
    outs("abt_c3", 2'b10, 4'b1111, 1'b1, 1'b0);
    cmd_if.abort = 1'b1;
    tick();
    outs("abt_idle", 2'b00, 4'b1111, 1'b0, 1'b0);
    chk("abt_ready_held", {7'd0, cmd_if.cmd_ready}, 8'd0);
    chk("abt_q", {4'd0, q}, 8'h07);
    cmd_if.abort = 1'b0;
    #1;
    chk("abt_ready", {7'd0, cmd_if.cmd_ready}, 8'd1);
    tick();
    chk("abt_no_done", {7'd0, done}, 8'd0);

    // Reset asserted mid-shift, then a load after release
    send(2'b01, 4'd5, 4'b0000, 1'b0);
    tick();
    cmd_if.cmd_valid = 1'b0;
    chk("rst_shift_busy", {7'd0, busy}, 8'd1);
    #2 reset = 1'b0;
    #1;
    outs("rst_async", 2'b00, 4'b0000, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    send(2'b11, 4'd0, 4'b0110, 1'b0);
    tick();
    outs("rst_load", 2'b11, 4'b0110, 1'b1, 1'b0);
    cmd_if.cmd_valid = 1'b0;
    tick();
    outs("rst_load_done", 2'b00, 4'b0110, 1'b0, 1'b1);
    chk("rst_q", {4'd0, q}, 8'h06);
    tick();

    // Back-to-back: valid held high across two commands
    send(2'b11, 4'd0, 4'b1100, 1'b0);
    tick();
    outs("b2b_load", 2'b11, 4'b1100, 1'b1, 1'b0);
    send(2'b01, 4'd1, 4'b0000, 1'b1);
    tick();
    outs("b2b_done1", 2'b00, 4'b1100, 1'b0, 1'b1);
    chk("b2b_ready_done", {7'd0, cmd_if.cmd_ready}, 8'd0);
    tick();
    outs("b2b_idle", 2'b00, 4'b1100, 1'b0, 1'b0);
    chk("b2b_ready_idle", {7'd0, cmd_if.cmd_ready}, 8'd1);
    tick();
    outs("b2b_shift", 2'b01, 4'b1111, 1'b1, 1'b0);
    cmd_if.cmd_valid = 1'b0;
    tick();
    outs("b2b_done2", 2'b00, 4'b1111, 1'b0, 1'b1);
    chk("b2b_q", {4'd0, q}, 8'h0e);
    tick();

    // Abort in IDLE blocks acceptance
    cmd_if.abort = 1'b1;
    send(2'b11, 4'd0, 4'b0001, 1'b0);
    #1;
    chk("idle_abort_ready", {7'd0, cmd_if.cmd_ready}, 8'd0);
    tick();
    outs("idle_abort", 2'b00, 4'b1111, 1'b0, 1'b0);
    cmd_if.abort     = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    tick();
    chk("idle_abort_q", {4'd0, q}, 8'h0e);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
